// File: rtl/mac_learn_table.sv
// mac_learn_table: source-learning MAC table with aging, station move, age-based eviction and flush.
// Optional statistics counters are compiled in when MAC_TABLE_STATS_EN is defined.
module mac_learn_table #(
    parameter int NUM_PORTS   = 4,
    parameter int NUM_ENTRIES = 16,
    parameter int ADDR_W      = 48,
    parameter int AGE_W       = 4,
    parameter int AGE_MAX     = 15,
    parameter int TICK_CYCLES = 1024,
    localparam int PORT_W     = $clog2(NUM_PORTS),
    localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              learn_valid_i,
    output logic              learn_ready_o,
    input  logic [ADDR_W-1:0] learn_addr_i,
    input  logic [PORT_W-1:0] learn_port_i,
    input  logic              lkup_valid_i,
    input  logic [ADDR_W-1:0] lkup_addr_i,
    output logic              rsp_valid_o,
    output logic              rsp_hit_o,
    output logic              rsp_flood_o,
    output logic [PORT_W-1:0] rsp_port_o,
    input  logic              flush_i,
    output logic              busy_o,
`ifdef MAC_TABLE_STATS_EN
    input  logic              stat_clr_i,
    output logic [31:0]       stat_hit_o,
    output logic [31:0]       stat_miss_o,
    output logic [31:0]       stat_evict_o,
`endif
    output logic [IDX_W:0]    entries_o
);
    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_AGE, S_FLUSH} state_t;

    state_t                  r_state, w_state_nxt;
    logic [IDX_W-1:0]        r_idx, w_idx_nxt;
    logic [TICK_W-1:0]       r_tick_cnt;
    logic                    r_pend;
    logic [NUM_ENTRIES-1:0]  r_valid;
    logic [ADDR_W-1:0]       r_addr [NUM_ENTRIES];
    logic [PORT_W-1:0]       r_port [NUM_ENTRIES];
    logic [AGE_W-1:0]        r_age  [NUM_ENTRIES];
    logic [IDX_W:0]          r_count;
    logic                    w_tick, w_go_age, w_last, w_age_op, w_expire, w_clear, w_learn;
    logic                    w_match, w_free, w_lk_hit;
    logic [IDX_W-1:0]        w_match_idx, w_free_idx, w_old_idx, w_wr_idx;
    logic [AGE_W-1:0]        w_old_age;
    logic [PORT_W-1:0]       w_lk_port;

    assign w_tick        = r_tick_cnt == TICK_W'(TICK_CYCLES - 1);
    assign w_go_age      = (r_state == S_IDLE) && !flush_i && (w_tick || r_pend);
    assign w_last        = r_idx == IDX_W'(NUM_ENTRIES - 1);
    assign w_age_op      = (r_state == S_AGE) && !flush_i && r_valid[r_idx];
    assign w_expire      = w_age_op && (r_age[r_idx] == AGE_W'(AGE_MAX));
    assign w_clear       = (r_state == S_FLUSH) && r_valid[r_idx];
    assign learn_ready_o = r_state == S_IDLE;
    assign busy_o        = r_state != S_IDLE;
    assign entries_o     = r_count;
    assign w_learn       = learn_valid_i && learn_ready_o && !learn_addr_i[ADDR_W-8];
    assign w_wr_idx      = w_match ? w_match_idx : (w_free ? w_free_idx : w_old_idx);

    // Learn-side search: existing match, lowest free slot, and oldest entry (lowest index on tie)
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        w_free      = 1'b0;
        w_free_idx  = '0;
        w_old_idx   = '0;
        w_old_age   = r_age[0];
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && r_addr[i] == learn_addr_i) begin
                w_match     = 1'b1;
                w_match_idx = IDX_W'(i);
            end
            if (!r_valid[i]) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
        for (int i = 1; i < NUM_ENTRIES; i++) begin
            if (r_age[i] > w_old_age) begin
                w_old_age = r_age[i];
                w_old_idx = IDX_W'(i);
            end
        end
    end

    // Lookup search against the current (pre-update) table; group addresses never hit
    always_comb begin
        w_lk_hit  = 1'b0;
        w_lk_port = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (r_valid[i] && r_addr[i] == lkup_addr_i && !lkup_addr_i[ADDR_W-8]) begin
                w_lk_hit  = 1'b1;
                w_lk_port = r_port[i];
            end
        end
    end

    // Sweep FSM next state: flush wins everywhere and restarts at index 0
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (flush_i) begin
            w_state_nxt = S_FLUSH;
            w_idx_nxt   = '0;
        end else if (w_go_age) begin
            w_state_nxt = S_AGE;
            w_idx_nxt   = '0;
        end else if (r_state != S_IDLE) begin
            w_state_nxt = w_last ? S_IDLE : r_state;
            w_idx_nxt   = r_idx + 1'b1;
        end
    end

    // Sweep FSM state and index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Aging tick counter and single pending-tick latch for ticks that arrive while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_pend     <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_pend     <= w_go_age ? 1'b0 : (r_pend || w_tick);
        end
    end

    // Table storage: learns only happen in IDLE, so they never collide with sweep writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_addr[i] <= '0;
                r_port[i] <= '0;
                r_age[i]  <= '0;
            end
        end else if (w_learn) begin
            r_valid[w_wr_idx] <= 1'b1;
            r_addr[w_wr_idx]  <= learn_addr_i;
            r_port[w_wr_idx]  <= learn_port_i;
            r_age[w_wr_idx]   <= '0;
        end else if (w_expire || w_clear) begin
            r_valid[r_idx] <= 1'b0;
        end else if (w_age_op) begin
            r_age[r_idx] <= r_age[r_idx] + 1'b1;
        end
    end

    // Valid-entry count: moves, refreshes and evictions leave it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_count <= '0;
        else if (w_learn && !w_match && w_free) r_count <= r_count + 1'b1;
        else if (w_expire || w_clear) r_count <= r_count - 1'b1;
    end

    // Registered lookup response; port forced to 0 on miss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_o <= 1'b0;
            rsp_hit_o   <= 1'b0;
            rsp_flood_o <= 1'b0;
            rsp_port_o  <= '0;
        end else begin
            rsp_valid_o <= lkup_valid_i;
            rsp_hit_o   <= lkup_valid_i && w_lk_hit;
            rsp_flood_o <= lkup_valid_i && !w_lk_hit;
            rsp_port_o  <= (lkup_valid_i && w_lk_hit) ? w_lk_port : '0;
        end
    end

`ifdef MAC_TABLE_STATS_EN
    logic [31:0] r_stat_hit, r_stat_miss, r_stat_evict;
    assign stat_hit_o   = r_stat_hit;
    assign stat_miss_o  = r_stat_miss;
    assign stat_evict_o = r_stat_evict;

    // Saturating statistics counters, counted on responses and full-table replacements
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || stat_clr_i) begin
            r_stat_hit   <= '0;
            r_stat_miss  <= '0;
            r_stat_evict <= '0;
        end else begin
            if (rsp_valid_o && rsp_hit_o && ~&r_stat_hit) r_stat_hit <= r_stat_hit + 1'b1;
            if (rsp_valid_o && !rsp_hit_o && ~&r_stat_miss) r_stat_miss <= r_stat_miss + 1'b1;
            if (w_learn && !w_match && !w_free && ~&r_stat_evict) r_stat_evict <= r_stat_evict + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mac_learn_table.sv
// tb_mac_learn_table: scoreboard bench for mac_learn_table (default config plus a fast-aging instance)
module tb_mac_learn_table;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    logic        learn_valid_i = 1'b0, learn_ready_o;
    logic [47:0] learn_addr_i = '0;
    logic [1:0]  learn_port_i = '0;
    logic        lkup_valid_i = 1'b0;
    logic [47:0] lkup_addr_i = '0;
    logic        rsp_valid_o, rsp_hit_o, rsp_flood_o;
    logic [1:0]  rsp_port_o;
    logic        flush_i = 1'b0, busy_o;
    logic [4:0]  entries_o;

    logic        a_learn_valid = 1'b0, a_ready;
    logic [47:0] a_learn_addr = '0;
    logic [1:0]  a_learn_port = '0;
    logic        a_lkup_valid = 1'b0;
    logic [47:0] a_lkup_addr = '0;
    logic        a_rsp_valid, a_rsp_hit, a_rsp_flood;
    logic [1:0]  a_rsp_port;
    logic        a_flush = 1'b0, a_busy;
    logic [4:0]  a_entries;

`ifdef MAC_TABLE_STATS_EN
    logic        stat_clr_i = 1'b0;
    logic [31:0] stat_hit_o, stat_miss_o, stat_evict_o;
    logic [31:0] a_stat_hit, a_stat_miss, a_stat_evict;
`endif

    mac_learn_table u_dut (
        .clk(clk), .rst_n(rst_n),
        .learn_valid_i(learn_valid_i), .learn_ready_o(learn_ready_o),
        .learn_addr_i(learn_addr_i), .learn_port_i(learn_port_i),
        .lkup_valid_i(lkup_valid_i), .lkup_addr_i(lkup_addr_i),
        .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o), .rsp_flood_o(rsp_flood_o), .rsp_port_o(rsp_port_o),
        .flush_i(flush_i), .busy_o(busy_o),
`ifdef MAC_TABLE_STATS_EN
        .stat_clr_i(stat_clr_i), .stat_hit_o(stat_hit_o), .stat_miss_o(stat_miss_o), .stat_evict_o(stat_evict_o),
`endif
        .entries_o(entries_o)
    );

    mac_learn_table #(.TICK_CYCLES(4), .AGE_MAX(2)) u_age (
        .clk(clk), .rst_n(rst_n),
        .learn_valid_i(a_learn_valid), .learn_ready_o(a_ready),
        .learn_addr_i(a_learn_addr), .learn_port_i(a_learn_port),
        .lkup_valid_i(a_lkup_valid), .lkup_addr_i(a_lkup_addr),
        .rsp_valid_o(a_rsp_valid), .rsp_hit_o(a_rsp_hit), .rsp_flood_o(a_rsp_flood), .rsp_port_o(a_rsp_port),
        .flush_i(a_flush), .busy_o(a_busy),
`ifdef MAC_TABLE_STATS_EN
        .stat_clr_i(stat_clr_i), .stat_hit_o(a_stat_hit), .stat_miss_o(a_stat_miss), .stat_evict_o(a_stat_evict),
`endif
        .entries_o(a_entries)
    );

    typedef struct {
        string      tag;
        logic       hit;
        logic [1:0] port;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   n_chk = 0, n_err = 0, n_hit = 0, n_miss = 0;

    localparam logic [47:0] A = 48'h00_11_22_33_44_55;
    localparam logic [47:0] B = 48'h00_BB_00_00_00_0B;
    localparam logic [47:0] C = 48'h00_00_00_00_0C_01;
    localparam logic [47:0] D = 48'h00_00_00_00_0D_01;
    localparam logic [47:0] G = 48'h01_00_5E_00_00_01;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [47:0] ent_addr(input int i);
        return 48'h00_00_00_00_10_00 + 48'(i);
    endfunction

    task automatic learn(input logic [47:0] a, input logic [1:0] p);
        int n = 0;
        learn_valid_i = 1'b1;
        learn_addr_i  = a;
        learn_port_i  = p;
        while (!learn_ready_o && n < 200) begin
            step(1);
            n++;
        end
        chk("learn_wait", 64'(n < 200), 1);
        step(1);
        learn_valid_i = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [47:0] a, input logic h, input logic [1:0] p);
        exp_t e;
        e.tag  = tag;
        e.hit  = h;
        e.port = h ? p : 2'd0;
        exp_q.push_back(e);
        if (h) n_hit++;
        else n_miss++;
        lkup_valid_i = 1'b1;
        lkup_addr_i  = a;
        step(1);
        lkup_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step(1);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 0);
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        step(1);
        flush_i = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy_o && n < 100) begin
            step(1);
            n++;
        end
    endtask

    task automatic wait_sweep();
        int n = 0;
        while (!busy_o && n < 1200) begin
            step(1);
            n++;
        end
        chk("sweep_start", 64'(busy_o), 1);
    endtask

    // Response scoreboard: every response must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && rsp_valid_o) begin
            if (exp_q.size() == 0) chk("rsp_extra", 1, 0);
            else begin
                m_e = exp_q.pop_front();
                chk(m_e.tag, {rsp_hit_o, rsp_flood_o, rsp_port_o}, {m_e.hit, !m_e.hit, m_e.port});
            end
        end
    end

    task automatic run_main();
        int n;
        learn(A, 2);
        lookup("lk_A", A, 1, 2);
        chk("ent_A", entries_o, 1);
        lookup("lk_bcast", 48'hFF_FF_FF_FF_FF_FF, 0, 0);
        lookup("lk_unknown", 48'h00_AA_BB_CC_DD_EE, 0, 0);
        learn(G, 1);
        chk("ent_group_src", entries_o, 1);
        lookup("lk_group", G, 0, 0);
        learn(C, 1);
        learn(C, 3);
        chk("ent_move", entries_o, 2);
        lookup("lk_move", C, 1, 3);
        chk("same_cycle_ready", 64'(learn_ready_o), 1);
        learn_valid_i = 1'b1;
        learn_addr_i  = D;
        learn_port_i  = 2'd0;
        m_e.tag = "lk_same_cycle";
        m_e.hit = 1'b0;
        m_e.port = 2'd0;
        exp_q.push_back(m_e);
        n_miss++;
        lkup_valid_i = 1'b1;
        lkup_addr_i  = D;
        step(1);
        learn_valid_i = 1'b0;
        lkup_valid_i  = 1'b0;
        lookup("lk_D_after", D, 1, 0);
        chk("ent_D", entries_o, 3);
        drain();
        pulse_flush();
        busy_len(n);
        chk("flush_busy_len", 64'(n), 16);
        chk("flush_ent", entries_o, 0);
        lookup("lk_after_flush", A, 0, 0);
        for (int i = 0; i < 16; i++) learn(ent_addr(i), 2'(i));
        chk("fill_ent", entries_o, 16);
        lookup("lk_fill5", ent_addr(5), 1, 2'd1);
        wait_sweep();
        busy_len(n);
        chk("sweep_len", 64'(n), 16);
        for (int i = 0; i < 16; i++) if (i != 5) learn(ent_addr(i), 2'(i));
        chk("refresh_ent", entries_o, 16);
        learn(B, 2);
        chk("evict_ent", entries_o, 16);
        lookup("lk_B", B, 1, 2);
        lookup("lk_evicted5", ent_addr(5), 0, 0);
        lookup("lk_kept4", ent_addr(4), 1, 0);
        lookup("lk_kept6", ent_addr(6), 1, 2);
        drain();
        wait_sweep();
        step(3);
        pulse_flush();
        busy_len(n);
        chk("flush_mid_age_len", 64'(n), 16);
        chk("flush_mid_age_ent", entries_o, 0);
        lookup("lk_B_flushed", B, 0, 0);
        drain();
`ifdef MAC_TABLE_STATS_EN
        step(2);
        chk("stat_hit", stat_hit_o, 64'(n_hit));
        chk("stat_miss", stat_miss_o, 64'(n_miss));
        chk("stat_evict", stat_evict_o, 1);
        stat_clr_i = 1'b1;
        step(1);
        stat_clr_i = 1'b0;
        chk("stat_clr", {stat_hit_o, stat_miss_o}, 0);
`endif
    endtask

    task automatic run_age();
        int n = 0;
        a_learn_valid = 1'b1;
        a_learn_addr  = A;
        a_learn_port  = 2'd1;
        while (!a_ready && n < 100) begin
            step(1);
            n++;
        end
        chk("age_learn_wait", 64'(n < 100), 1);
        step(1);
        a_learn_valid = 1'b0;
        chk("age_ent_learn", a_entries, 1);
        for (int s = 1; s <= 3; s++) begin
            n = 0;
            while (a_ready && n < 20) begin
                step(1);
                n++;
            end
            n = 0;
            while (!a_ready && n < 100) begin
                step(1);
                n++;
            end
            chk($sformatf("age_sweep%0d_len", s), 64'(n), 16);
            chk($sformatf("age_sweep%0d_ent", s), a_entries, (s < 3) ? 64'd1 : 64'd0);
        end
    endtask

    initial begin
        step(3);
        chk("rst_ready", 64'(learn_ready_o), 1);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_entries", entries_o, 0);
        chk("rst_rsp", {rsp_valid_o, rsp_hit_o, rsp_flood_o, rsp_port_o}, 0);
        chk("rst_age_ready", 64'(a_ready), 1);
        rst_n = 1'b1;
        fork
            run_main();
            run_age();
        join
        learn(A, 1);
        chk("pre_rst_ent", entries_o, 1);
        pulse_flush();
        step(3);
        rst_n = 1'b0;
        #1;
        chk("midflush_rst_busy", 64'(busy_o), 0);
        chk("midflush_rst_ready", 64'(learn_ready_o), 1);
        chk("midflush_rst_ent", entries_o, 0);
        step(2);
        rst_n = 1'b1;
        step(5);
        chk("post_rst_idle", {busy_o, learn_ready_o}, 2'b01);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
